// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: one shift-add or
// restoring shift-subtract step per cycle on operand magnitudes, sign fix-up at the end.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic                is_div_r;
  logic                q_neg_r;
  logic                r_neg_r;
  logic                dz_pend_r;
  logic [WIDTH-1:0]    opb_r;
  logic [2*WIDTH-1:0]  acc_r;
  logic [WIDTH-1:0]    rem_r;

  logic                a_neg_s;
  logic                b_neg_s;
  logic [WIDTH-1:0]    a_mag_s;
  logic [WIDTH-1:0]    b_mag_s;
  logic [WIDTH:0]      mul_add_s;
  logic [WIDTH:0]      mul_sum_s;
  logic [WIDTH:0]      div_shift_s;
  logic [WIDTH:0]      div_diff_s;
  logic [2*WIDTH-1:0]  prod_s;
  logic [WIDTH-1:0]    quo_s;
  logic [WIDTH-1:0]    rem_fix_s;
  logic [WIDTH-1:0]    res_hi_s;
  logic [WIDTH-1:0]    res_lo_s;

  // Operand sign-magnitude conversion; MULTU/DIVU (op[0]=1) pass operands unchanged.
  always_comb begin
    a_neg_s = ~op[0] & opr1[WIDTH-1];
    b_neg_s = ~op[0] & opr2[WIDTH-1];
    if (a_neg_s) a_mag_s = -opr1;
    else         a_mag_s = opr1;
    if (b_neg_s) b_mag_s = -opr2;
    else         b_mag_s = opr2;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    if (acc_r[0]) mul_add_s = {1'b0, opb_r};
    else          mul_add_s = '0;
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + mul_add_s;
    div_shift_s = {rem_r, acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_r};
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient, and the remainder
  // path already reproduces the original dividend in that case.
  always_comb begin
    if (q_neg_r) prod_s = -acc_r;
    else         prod_s = acc_r;
    if (dz_pend_r)    quo_s = '1;
    else if (q_neg_r) quo_s = -acc_r[WIDTH-1:0];
    else              quo_s = acc_r[WIDTH-1:0];
    if (r_neg_r) rem_fix_s = -rem_r;
    else         rem_fix_s = rem_r;
    if (is_div_r) begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_s;
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      is_div_r  <= 1'b0;
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      dz_pend_r <= 1'b0;
      opb_r     <= '0;
      acc_r     <= '0;
      rem_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div_r  <= op[1];
            q_neg_r   <= a_neg_s ^ b_neg_s;
            r_neg_r   <= a_neg_s;
            dz_pend_r <= op[1] & (opr2 == '0);
            // Low half holds the multiplier for MULT, the dividend for DIV.
            acc_r     <= {{WIDTH{1'b0}}, (op[1] ? a_mag_s : b_mag_s)};
            opb_r     <= op[1] ? b_mag_s : a_mag_s;
            rem_r     <= '0;
            cnt_r     <= '0;
            busy      <= 1'b1;
            state_r   <= RUN;
          end
        end
        RUN: begin
          if (cancel) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            if (is_div_r) begin
              acc_r[WIDTH-1:0] <= {acc_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
              rem_r <= div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
            end else begin
              acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
            end
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CW'(WIDTH - 1)) state_r <= FINISH;
          end
        end
        FINISH: begin
          busy    <= 1'b0;
          state_r <= IDLE;
          if (!cancel) begin
            hi   <= res_hi_s;
            lo   <= res_lo_s;
            dz   <= dz_pend_r;
            done <= 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): expected HI/LO/DZ pushed to a
// scoreboard at issue time and popped when done pulses.
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, start, cancel, hi_we, lo_we;
  logic [1:0] op;
  logic [W-1:0] opr1, opr2, wdata;
  logic busy, done, dz;
  logic [W-1:0] hi, lo;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int e0 = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opr1(opr1), .opr2(opr2),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; opr1 = a; opr2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    opr1 = $urandom;
    opr2 = $urandom;
    op = 2'($urandom_range(0, 3));
  endtask

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = d;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int n;
    exp_t e;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(cyc - e0), 64'd33);
    check({tag, " busy"}, 64'(busy), 64'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " hi"}, 64'(hi), 64'(e.hi));
      check({tag, " lo"}, 64'(lo), 64'(e.lo));
      check({tag, " dz"}, 64'(dz), 64'(e.dz));
    end else begin
      compared++;
      mismatched++;
      $error("FAIL %s scoreboard: observed empty expected entry", tag);
    end
  endtask

  initial begin
    int pulses;
    reset = 1'b0; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; opr1 = '0; opr2 = '0; wdata = '0;
    #2 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset dz", 64'(dz), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
    check("mult busy after start", 64'(busy), 64'd1);
    check("mult hi held", 64'(hi), 64'd0);
    wait_done("mult -1*2");

    push(32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done("multu");

    push(32'h0000_0000, 32'h0000_000F, 1'b0);
    issue(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    wait_done("mult -3*-5");

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div -7/2");

    push(32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    issue(2'b10, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done("div 7/-2");

    push(32'h0000_0001, 32'h0000_0003, 1'b0);
    issue(2'b11, 32'h0000_0007, 32'h0000_0002);
    wait_done("divu 7/2");

    push(32'h0000_0000, 32'h8000_0000, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div min/-1");

    push(32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    issue(2'b11, 32'h0000_0005, 32'h0000_0000);
    wait_done("divu 5/0");
    repeat (3) tick();
    check("dz sticky", 64'(dz), 64'd1);

    // Ignored start and ignored MTLO while busy, then back-to-back start in done cycle.
    push(32'h0000_0002, 32'h0000_000E, 1'b0);
    issue(2'b11, 32'd100, 32'd7);
    repeat (5) tick();
    start = 1'b1; op = 2'b11; opr1 = 32'd9; opr2 = 32'd3;
    tick();
    start = 1'b0;
    lo_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    lo_we = 1'b0;
    check("mtlo while busy", 64'(lo), 64'hFFFF_FFFF);
    wait_done("divu 100/7");
    push(32'h0000_0001, 32'h0000_0000, 1'b0);
    issue(2'b01, 32'h0001_0000, 32'h0001_0000);
    wait_done("back-to-back multu");

    hi_we = 1'b1; wdata = 32'h0000_ABCD;
    tick();
    hi_we = 1'b0;
    check("mthi idle", 64'(hi), 64'h0000_ABCD);

    issue(2'b01, 32'd5, 32'd6);
    repeat (10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel hi", 64'(hi), 64'h0000_ABCD);
    check("cancel lo", 64'(lo), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      tick();
    end
    check("cancel no done", 64'(pulses), 64'd0);

    push(32'h0000_0009, 32'hFFFF_FFFF, 1'b1);
    issue(2'b11, 32'd9, 32'd0);
    wait_done("divu 9/0");

    issue(2'b01, 32'd3, 32'd4);
    repeat (5) tick();
    #3 reset = 1'b1;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset dz", 64'(dz), 64'd0);
    check("async reset hi", 64'(hi), 64'd0);
    check("async reset lo", 64'(lo), 64'd0);
    #2 reset = 1'b0;
    tick();
    push(32'h0000_0000, 32'h0000_000C, 1'b0);
    issue(2'b01, 32'd3, 32'd4);
    wait_done("multu after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers. It gives the CPU the MULT/MULTU/DIV/DIVU/MTHI/MTLO capability that the single-cycle datapath lacks. The CPU issues an operation with a one-cycle `start`, stalls on `busy`, and reads `hi`/`lo` afterwards. The unit runs one shift-add or shift-subtract step per cycle, so latency scales with `WIDTH`.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Legal range is `WIDTH` ≥ 4, even.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset. One clock domain only.
- `start`, input, 1: request an operation. Sampled only while `busy`=0.
- `op`, input, 2: operation select. 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `opr1`, input, `WIDTH`: multiplicand or dividend (rs).
- `opr2`, input, `WIDTH`: multiplier or divisor (rt).
- `cancel`, input, 1: abort the running operation.
- `hi_we`, input, 1: MTHI write enable.
- `lo_we`, input, 1: MTLO write enable.
- `wdata`, input, `WIDTH`: data for MTHI/MTLO.
- `busy`, output, 1: operation in progress; the CPU stalls.
- `done`, output, 1: one-cycle pulse; `hi`/`lo` have just been updated by an operation.
- `dz`, output, 1: the last completed divide had a zero divisor. Sticky until the next completion.
- `hi`, output, `WIDTH`: HI register (product high half, or remainder).
- `lo`, output, `WIDTH`: LO register (product low half, or quotient).

## Operation
- **States:** IDLE, RUN, FINISH.
- **IDLE:**
  - `start`=1 latches `op`, |`opr1`|, |`opr2`| and the result-sign flags. Operands are sign-magnitude converted for MULT/DIV; for MULTU/DIVU they pass unchanged.
  - The step counter is cleared and the state moves to RUN.
- **RUN:** one iteration per cycle for exactly `WIDTH` cycles, then FINISH. Counter width is clog2(`WIDTH`)+1.
  - Multiply: shift-add into a 2·`WIDTH` accumulator.
  - Divide: restoring shift-subtract. The partial remainder is `WIDTH`+1 bits to hold the borrow.
- **FINISH (one cycle):** apply the sign fix-up, write `hi`/`lo`, set `done`=1 and `dz`, then return to IDLE.
- **Signed results:**
  - Product is negated if the operand signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- **MIN / −1 (DIV):** `lo`=MIN, `hi`=0. This falls out of the magnitude method; no special case is needed.
- **Divide by zero (DIV or DIVU):** `lo`=all ones, `hi`=original `opr1`, `dz`=1.
- **MTHI/MTLO:**
  - In IDLE, `hi_we`/`lo_we` write `wdata` at the clock edge.
  - While `busy`=1 these writes are ignored.
  - If a write and `start` occur together in IDLE, both take effect. The write lands now and the operation result overwrites it later.
- **`start` handling:**
  - `start` while `busy`=1 is ignored; nothing is queued.
  - `start` in the cycle where `done`=1 is accepted, because `busy` is already 0.
- **`cancel`:**
  - In RUN or FINISH, `cancel`=1 returns the unit to IDLE at the next edge.
  - There is no `hi`/`lo`/`dz` update and no `done` pulse.
  - `cancel` in IDLE has no effect, and `cancel` takes priority over FINISH.

## Timing
- **Reset:** asynchronous. All outputs go to 0 immediately (`busy`, `done`, `dz`, `hi`, `lo`) and the state goes to IDLE. Reset in the middle of an operation discards it.
- **Start edge:** E0, the edge that samples `start`=1 in IDLE.
- **`busy`:** 1 during the cycles following E0 through E(`WIDTH`+1), i.e. `WIDTH`+1 cycles.
  - `busy` is a registered output, asserted starting the cycle after E0. The CPU must hold its own stall in the issue cycle.
- **Result edge:** `hi`/`lo`/`dz` update at E(`WIDTH`+1).
- **Pulse cycle:** `done`=1 and `busy`=0 during the cycle after E(`WIDTH`+1).
- **Latency:** `WIDTH`+1 cycles from start edge to valid result; 33 cycles at `WIDTH`=32.
- **Output stability:** `hi`/`lo` are stable at all other times and are never exposed mid-computation.
- **Operands:** `opr1`/`opr2` need only be valid at E0.

## Test plan
All scenarios use `WIDTH`=32.
- **Multiply:** MULT 0xFFFFFFFF × 0x00000002 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, `done` high exactly 33 cycles after E0. MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **Signed/unsigned divide:** DIV 0xFFFFFFF9 (−7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7 / 2 → `lo`=3, `hi`=1, `dz`=0.
- **Divide boundaries:** DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIVU 5 / 0 → `lo`=0xFFFFFFFF, `hi`=5, `dz`=1.
- **Handshake:**
  - A second `start` while `busy`=1 has no effect on the result.
  - Back-to-back `start` in the `done` cycle yields a second result 33 cycles later.
  - MTLO 0x1234 while busy is ignored; MTHI 0xABCD in IDLE reads back as `hi`=0xABCD.
- **Cancel:** `cancel` at RUN cycle 10 → `busy`=0 next cycle, `hi`/`lo` keep their prior values, no `done` pulse.
- **Reset:** assert `reset` asynchronously mid-RUN, between edges → `busy`/`hi`/`lo`/`done`/`dz` go to 0 before the next edge; a new `start` after release works normally.
